exception_request_ctrl: RTL and testbench
=========================================

EXCEPTION_REQUEST_CTRL -- requirements
Module: exception_request_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 4, is the number of consecutive disagreeing cycles before a debounced level flips; legal range 1..65535.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 expSrc0  in  1  raw, asynchronous exception source 0, lowest priority, code 2'd1.
REQ-005 expSrc1  in  1  raw, asynchronous exception source 1, code 2'd2.
REQ-006 expSrc2  in  1  raw, asynchronous exception source 2, highest priority, code 2'd3.
REQ-007 int_en  in  1  CPU global exception enable, sampled in IDLE only.
REQ-008 exp_ack  in  1  CPU accepts the presented request; one-cycle pulse.
REQ-009 eret  in  1  CPU return-from-handler; one-cycle pulse.
REQ-010 exp_req  out  1  request to CPU, registered.
REQ-011 exp_code  out  2  code of the presented request; 0 when no request is held.
REQ-012 pending  out  3  latched, not-yet-accepted events, bit i = expSrc i.
REQ-013 in_service  out  2  code currently being serviced; 0 when none.
REQ-014 exp_count  out  32  total accepted requests.

Function
REQ-015 Each source passes through a 2-flop synchronizer; nothing downstream uses a raw input.
REQ-016 Debounce per source: a 16-bit counter increments each cycle sync output differs from the debounced level, clears on agreement, and the debounced level flips on the edge where the count reaches DB_CYCLES, with the counter cleared on that edge.
REQ-017 A 0->1 debounced transition sets pending[i] on the next edge; a 1->0 transition has no effect.
REQ-018 FSM states IDLE, REQ, SERVICE; reset state is IDLE.
REQ-019 In IDLE, when int_en=1 and pending!=0, the next edge moves to REQ with exp_req=1 and exp_code=highest-priority pending code.
REQ-020 In REQ, exp_req and exp_code remain stable until exp_ack; int_en deassertion and newly arriving higher-priority events do not change them.
REQ-021 exp_ack in REQ → next edge: clear the corresponding pending bit, exp_count+1, in_service=exp_code, exp_req=0, exp_code=0, state SERVICE.
REQ-022 In SERVICE, new edges still set pending; no request is raised; eret → next edge IDLE, in_service=0.
REQ-023 Back-to-back: with pending still nonzero and int_en=1, exp_req reasserts on the edge after the return to IDLE, giving one IDLE cycle minimum between requests.
REQ-024 exp_ack outside REQ and eret outside SERVICE are ignored.
REQ-025 If a pending bit is set by a new edge in the same cycle it is cleared by acceptance, the set wins and the bit stays 1.
REQ-026 exp_count wraps from 0xFFFFFFFF to 0 without flagging.
REQ-027 Latency: raw rise sampled at edge 0 → exp_req high after edge 2+DB_CYCLES+1 (the 8th edge for DB_CYCLES=4), given IDLE and int_en=1.

Reset
REQ-028 rst=1 immediately forces exp_req=0, exp_code=0, pending=0, in_service=0, exp_count=0, state IDLE, and all synchronizer, debounce and debounced-level flops to 0, including mid-REQ or mid-SERVICE.
REQ-029 After rst falls, a source held high is treated as a new rising event and is debounced normally.

Verification
REQ-030 DB_CYCLES=4, int_en=1, expSrc1 rises and is held → pending=3'b010 after edge 7, exp_req=1 and exp_code=2 after edge 8; exp_ack → exp_req=0, in_service=2, exp_count=1, pending=0.
REQ-031 expSrc1 pulses high for 3 cycles, then low → pending and exp_req never set.
REQ-032 expSrc0 and expSrc2 rise together → exp_code=3 first; after ack and eret, exp_code=1 on the following request; exp_count=2.
REQ-033 In REQ with exp_code=1, expSrc2 rises → exp_code stays 1 until ack; pending[2]=1; request code 3 follows after eret.
REQ-034 int_en=0 with pending=3'b100 → exp_req stays 0 indefinitely; int_en=1 → exp_req=1 on the next edge.
REQ-035 rst asserted in SERVICE with pending=3'b011 → all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/exception_request_ctrl_if.sv
// CPU-side handshake bundle of the exception request controller.
// master = controller, slave = CPU.
interface exception_request_ctrl_if;
  logic        int_en;
  logic        exp_ack;
  logic        eret;
  logic        exp_req;
  logic [1:0]  exp_code;
  logic [2:0]  pending;
  logic [1:0]  in_service;
  logic [31:0] exp_count;

  modport master (
    input  int_en, exp_ack, eret,
    output exp_req, exp_code, pending, in_service, exp_count
  );

  modport slave (
    output int_en, exp_ack, eret,
    input  exp_req, exp_code, pending, in_service, exp_count
  );
endinterface

// File: rtl/exception_request_ctrl.sv
// Synchronizes and debounces three raw exception sources, latches their rising
// edges and presents them one at a time to the CPU by fixed priority.
module exception_request_ctrl #(
  parameter int DB_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      expSrc0,
  input  logic                      expSrc1,
  input  logic                      expSrc2,
  exception_request_ctrl_if.master  cpu
);

  localparam logic [15:0] DB_LIM = 16'(DB_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  logic [2:0]  raw;
  logic [2:0]  sync1_q, sync2_q;
  logic [2:0]  level_q, level_d, level_prev_q;
  logic [15:0] db_cnt_q [3];
  logic [15:0] db_cnt_d [3];
  logic [2:0]  rise;
  logic [2:0]  clr;

  state_t      state_q, state_d;
  logic        exp_req_q, exp_req_d;
  logic [1:0]  exp_code_q, exp_code_d;
  logic [2:0]  pending_q, pending_d;
  logic [1:0]  in_service_q, in_service_d;
  logic [31:0] exp_count_q, exp_count_d;

  assign raw = {expSrc2, expSrc1, expSrc0};

  function automatic logic [1:0] top_code(input logic [2:0] p);
    if (p[2])      return 2'd3;
    else if (p[1]) return 2'd2;
    else           return 2'd1;
  endfunction

  // The counter only runs while the synchronized input disagrees with the level.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] + 16'd1 == DB_LIM)
          level_d[i] = ~level_q[i];
        else
          db_cnt_d[i] = db_cnt_q[i] + 16'd1;
      end
    end
  end

  assign rise = level_q & ~level_prev_q;

  always_comb begin
    state_d      = state_q;
    exp_req_d    = exp_req_q;
    exp_code_d   = exp_code_q;
    in_service_d = in_service_q;
    exp_count_d  = exp_count_q;
    clr          = '0;
    case (state_q)
      IDLE: begin
        if (cpu.int_en && (pending_q != 3'b000)) begin
          state_d    = REQ;
          exp_req_d  = 1'b1;
          exp_code_d = top_code(pending_q);
        end
      end
      REQ: begin
        if (cpu.exp_ack) begin
          clr[exp_code_q - 2'd1] = 1'b1;
          exp_count_d  = exp_count_q + 32'd1;
          in_service_d = exp_code_q;
          exp_req_d    = 1'b0;
          exp_code_d   = 2'd0;
          state_d      = SERVICE;
        end
      end
      SERVICE: begin
        if (cpu.eret) begin
          state_d      = IDLE;
          in_service_d = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new edge on the accepted source outranks its clear.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      state_q      <= IDLE;
      exp_req_q    <= 1'b0;
      exp_code_q   <= 2'd0;
      pending_q    <= '0;
      in_service_q <= 2'd0;
      exp_count_q  <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q      <= state_d;
      exp_req_q    <= exp_req_d;
      exp_code_q   <= exp_code_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      exp_count_q  <= exp_count_d;
    end
  end

  assign cpu.exp_req    = exp_req_q;
  assign cpu.exp_code   = exp_code_q;
  assign cpu.pending    = pending_q;
  assign cpu.in_service = in_service_q;
  assign cpu.exp_count  = exp_count_q;

endmodule

// File: tb/tb_exception_request_ctrl.sv
// Scenario tasks plus a randomized run, all checked against a window-based
// behavioural model of debounce, latching and request arbitration.
module tb_exception_request_ctrl;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst;
  logic expSrc0, expSrc1, expSrc2;

  exception_request_ctrl_if cpu_if ();

  exception_request_ctrl #(.DB_CYCLES(DB)) dut (
    .clk     (clk),
    .rst     (rst),
    .expSrc0 (expSrc0),
    .expSrc1 (expSrc1),
    .expSrc2 (expSrc2),
    .cpu     (cpu_if)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Model: raw sample history since reset, levels, and the request bookkeeping.
  bit [2:0]  hist [0:8191];
  int        m_n;
  bit [2:0]  m_lvl, m_lvl_prev, m_pend;
  int        m_mode;
  bit [1:0]  m_code, m_svc;
  bit [31:0] m_cnt;

  function automatic bit sample(input int k, input int i);
    if (k < 0) return 1'b0;
    return hist[k][i];
  endfunction

  function automatic logic [39:0] dut_out();
    return {cpu_if.exp_req, cpu_if.exp_code, cpu_if.pending, cpu_if.in_service, cpu_if.exp_count};
  endfunction

  function automatic logic [39:0] model_out();
    return {(m_mode == 1), m_code, m_pend, m_svc, m_cnt};
  endfunction

  task automatic model_reset();
    m_n = 0; m_lvl = '0; m_lvl_prev = '0; m_pend = '0;
    m_mode = 0; m_code = '0; m_svc = '0; m_cnt = '0;
  endtask

  // A level flips once the last DB synchronized samples all differ from it.
  task automatic model_step(input bit [2:0] raw, input bit ie, input bit ack, input bit er);
    bit [2:0] new_lvl, rise, nxt;
    bit flip;
    if (m_n < 8192) hist[m_n] = raw;
    for (int i = 0; i < 3; i++) begin
      flip = 1'b1;
      for (int j = 0; j < DB; j++)
        if (sample(m_n - 2 - j, i) == m_lvl[i]) flip = 1'b0;
      new_lvl[i] = flip ? ~m_lvl[i] : m_lvl[i];
    end
    rise = m_lvl & ~m_lvl_prev;
    nxt  = m_pend;
    case (m_mode)
      0: if (ie && m_pend != 0) begin
           m_mode = 1;
           m_code = m_pend[2] ? 2'd3 : (m_pend[1] ? 2'd2 : 2'd1);
         end
      1: if (ack) begin
           nxt[int'(m_code) - 1] = 1'b0;
           m_cnt  = m_cnt + 1;
           m_svc  = m_code;
           m_code = 2'd0;
           m_mode = 2;
         end
      default: if (er) begin
           m_mode = 0;
           m_svc  = 2'd0;
         end
    endcase
    m_pend     = nxt | rise;
    m_lvl_prev = m_lvl;
    m_lvl      = new_lvl;
    m_n++;
  endtask

  task automatic step(input logic [2:0] raw, input logic ie, input logic ack, input logic er);
    {expSrc2, expSrc1, expSrc0} = raw;
    cpu_if.int_en  = ie;
    cpu_if.exp_ack = ack;
    cpu_if.eret    = er;
    model_step(raw, ie, ack, er);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {expSrc2, expSrc1, expSrc0} = 3'b000;
    cpu_if.int_en = 1'b0; cpu_if.exp_ack = 1'b0; cpu_if.eret = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (dut_out() !== 40'd0) begin
      nerr++;
      $display("[TB] FAIL reset_state: got %h expected %h", dut_out(), 40'd0);
    end
  endtask

  task automatic test_latency();
    do_reset();
    for (int k = 0; k < 6; k++) step(3'b010, 1, 0, 0);
    nvec++;
    if ({cpu_if.pending, cpu_if.exp_req} !== 4'b0000) begin
      nerr++; $display("[TB] FAIL latency_early: got %b expected 0000", {cpu_if.pending, cpu_if.exp_req});
    end
    step(3'b010, 1, 0, 0);
    nvec++;
    if ({cpu_if.pending, cpu_if.exp_req} !== 4'b0100) begin
      nerr++; $display("[TB] FAIL latency_pending: got %b expected 0100", {cpu_if.pending, cpu_if.exp_req});
    end
    step(3'b010, 1, 0, 0);
    nvec++;
    if ({cpu_if.exp_req, cpu_if.exp_code} !== 3'b110) begin
      nerr++; $display("[TB] FAIL latency_req: got %b expected 110", {cpu_if.exp_req, cpu_if.exp_code});
    end
    step(3'b010, 1, 1, 0);
    nvec++;
    if (dut_out() !== {1'b0, 2'd0, 3'b000, 2'd2, 32'd1} || dut_out() !== model_out()) begin
      nerr++; $display("[TB] FAIL latency_ack: got %h expected %h", dut_out(), {1'b0, 2'd0, 3'b000, 2'd2, 32'd1});
    end
    step(3'b010, 1, 0, 1);
    nvec++;
    if (cpu_if.in_service !== 2'd0 || cpu_if.exp_req !== 1'b0) begin
      nerr++; $display("[TB] FAIL latency_eret: got svc=%0d req=%b expected svc=0 req=0", cpu_if.in_service, cpu_if.exp_req);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int k = 0; k < 15; k++) begin
      step((k < 3) ? 3'b010 : 3'b000, 1, 0, 0);
      nvec++;
      if ({cpu_if.pending, cpu_if.exp_req} !== 4'b0000) begin
        nerr++; $display("[TB] FAIL glitch_step%0d: got %b expected 0000", k, {cpu_if.pending, cpu_if.exp_req});
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 8; k++) step(3'b101, 1, 0, 0);
    nvec++;
    if ({cpu_if.exp_req, cpu_if.exp_code, cpu_if.pending} !== 6'b111_101) begin
      nerr++; $display("[TB] FAIL prio_first: got %b expected 111101", {cpu_if.exp_req, cpu_if.exp_code, cpu_if.pending});
    end
    step(3'b101, 1, 1, 0);
    nvec++;
    if ({cpu_if.in_service, cpu_if.pending, cpu_if.exp_count} !== {2'd3, 3'b001, 32'd1}) begin
      nerr++; $display("[TB] FAIL prio_ack1: got %h expected %h", {cpu_if.in_service, cpu_if.pending, cpu_if.exp_count}, {2'd3, 3'b001, 32'd1});
    end
    step(3'b101, 1, 0, 1);
    nvec++;
    if ({cpu_if.exp_req, cpu_if.in_service} !== 3'b000) begin
      nerr++; $display("[TB] FAIL b2b_idle_gap: got %b expected 000", {cpu_if.exp_req, cpu_if.in_service});
    end
    step(3'b101, 1, 0, 0);
    nvec++;
    if ({cpu_if.exp_req, cpu_if.exp_code} !== 3'b101) begin
      nerr++; $display("[TB] FAIL b2b_second_req: got %b expected 101", {cpu_if.exp_req, cpu_if.exp_code});
    end
    step(3'b101, 1, 1, 0);
    nvec++;
    if (dut_out() !== {1'b0, 2'd0, 3'b000, 2'd1, 32'd2} || dut_out() !== model_out()) begin
      nerr++; $display("[TB] FAIL prio_ack2: got %h expected %h", dut_out(), {1'b0, 2'd0, 3'b000, 2'd1, 32'd2});
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    for (int k = 0; k < 8; k++) step(3'b001, 1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(3'b101, (k % 3) != 1, 0, 0);
      nvec++;
      if ({cpu_if.exp_req, cpu_if.exp_code} !== 3'b101) begin
        nerr++; $display("[TB] FAIL hold_req_step%0d: got %b expected 101", k, {cpu_if.exp_req, cpu_if.exp_code});
      end
    end
    nvec++;
    if (cpu_if.pending !== 3'b101) begin
      nerr++; $display("[TB] FAIL hold_pending: got %b expected 101", cpu_if.pending);
    end
    step(3'b101, 1, 1, 0);
    step(3'b101, 1, 0, 1);
    step(3'b101, 1, 0, 0);
    nvec++;
    if ({cpu_if.exp_req, cpu_if.exp_code, cpu_if.pending} !== 6'b111_100) begin
      nerr++; $display("[TB] FAIL preempt_followup: got %b expected 111100", {cpu_if.exp_req, cpu_if.exp_code, cpu_if.pending});
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    for (int k = 0; k < 8; k++) step(3'b001, 1, 0, 0);
    for (int k = 0; k < 8; k++) step(3'b000, 1, 0, 0);
    for (int k = 0; k < 6; k++) step(3'b001, 1, 0, 0);
    step(3'b001, 1, 1, 0);
    nvec++;
    if ({cpu_if.pending, cpu_if.in_service, cpu_if.exp_count} !== {3'b001, 2'd1, 32'd1} || dut_out() !== model_out()) begin
      nerr++; $display("[TB] FAIL set_wins: got %h expected %h", {cpu_if.pending, cpu_if.in_service, cpu_if.exp_count}, {3'b001, 2'd1, 32'd1});
    end
  endtask

  task automatic test_int_en();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(3'b100, 0, 0, 0);
      nvec++;
      if (cpu_if.exp_req !== 1'b0) begin
        nerr++; $display("[TB] FAIL int_en_blocked_step%0d: got %b expected 0", k, cpu_if.exp_req);
      end
    end
    nvec++;
    if (cpu_if.pending !== 3'b100) begin
      nerr++; $display("[TB] FAIL int_en_pending: got %b expected 100", cpu_if.pending);
    end
    step(3'b100, 1, 0, 0);
    nvec++;
    if ({cpu_if.exp_req, cpu_if.exp_code} !== 3'b111) begin
      nerr++; $display("[TB] FAIL int_en_release: got %b expected 111", {cpu_if.exp_req, cpu_if.exp_code});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 8; k++) step(3'b100, 1, 0, 0);
    step(3'b100, 1, 1, 0);
    for (int k = 0; k < 8; k++) step(3'b111, 1, 0, 0);
    nvec++;
    if ({cpu_if.pending, cpu_if.in_service} !== {3'b011, 2'd3}) begin
      nerr++; $display("[TB] FAIL service_setup: got %b expected 01111", {cpu_if.pending, cpu_if.in_service});
    end
    #1 rst = 1'b1;
    #1;
    nvec++;
    if (dut_out() !== 40'd0) begin
      nerr++; $display("[TB] FAIL async_reset: got %h expected %h", dut_out(), 40'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) step(3'b111, 1, 0, 0);
    nvec++;
    if ({cpu_if.exp_req, cpu_if.exp_code, cpu_if.pending} !== 6'b111_111 || dut_out() !== model_out()) begin
      nerr++; $display("[TB] FAIL held_after_reset: got %b expected 111111", {cpu_if.exp_req, cpu_if.exp_code, cpu_if.pending});
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    logic ie, ack, er;
    do_reset();
    r = 3'b000;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(7) == 0) r[i] = ~r[i];
      ie  = ($urandom_range(9) != 0);
      ack = ($urandom_range(3) == 0);
      er  = ($urandom_range(3) == 0);
      step(r, ie, ack, er);
      nvec++;
      if (dut_out() !== model_out()) begin
        nerr++;
        $display("[TB] FAIL random_cycle%0d: got %h expected %h", k, dut_out(), model_out());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    {expSrc2, expSrc1, expSrc0} = 3'b000;
    cpu_if.int_en = 1'b0; cpu_if.exp_ack = 1'b0; cpu_if.eret = 1'b0;
    model_reset();
    test_reset();
    test_latency();
    test_glitch();
    test_back_to_back();
    test_no_preempt();
    test_set_wins();
    test_int_en();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
